// File: rtl/button_debouncer.sv
// Debounces one push-button into level, single-shot, auto-repeat and continuous enables.
// Latency: press visible T+2 clocks after first PB sample; release T+3 clocks; outputs are state decodes.
// Backpressure: none; free-running, consumers sample the enables every clock.
module button_debouncer #(
    parameter int N_dc = 21
) (
    input  logic CLK,
    input  logic RESET,
    input  logic PB,
    output logic DPB,
    output logic SCEN,
    output logic MCEN,
    output logic CCEN
);

    localparam int TW = N_dc + 1;
    localparam logic [TW-1:0] T_M1  = TW'((1 << (N_dc - 1)) - 1);
    localparam logic [TW-1:0] T4_M1 = TW'((1 << (N_dc + 1)) - 1);

    typedef enum logic [2:0] {
        INI, W84, SCEN_ST, WS, MCEN_ST, MCEN_CONT, CCR, WFCR
    } state_t;

    state_t state, state_next;
    logic s1, s2;
    logic [TW-1:0] timer;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= INI;
            timer <= '0;
        end else begin
            s1    <= PB;
            s2    <= s1;
            state <= state_next;
            // Timer measures time spent in the current state only.
            timer <= (state_next != state) ? '0 : timer + TW'(1);
        end
    end

    // A low s2 is checked before the timer so release always wins a tie.
    always_comb begin
        state_next = INI;
        case (state)
            INI:       state_next = s2 ? W84 : INI;
            W84:       if (!s2) state_next = INI;
                       else if (timer == T_M1) state_next = SCEN_ST;
                       else state_next = W84;
            SCEN_ST:   state_next = WS;
            WS:        if (!s2) state_next = CCR;
                       else if (timer == T4_M1) state_next = MCEN_ST;
                       else state_next = WS;
            MCEN_ST:   state_next = MCEN_CONT;
            MCEN_CONT: if (!s2) state_next = CCR;
                       else if (timer == T_M1) state_next = MCEN_ST;
                       else state_next = MCEN_CONT;
            CCR:       state_next = WFCR;
            WFCR:      if (s2) state_next = WS;
                       else if (timer == T_M1) state_next = INI;
                       else state_next = WFCR;
            default:   state_next = INI;
        endcase
    end

    always_comb begin
        DPB  = 1'b0;
        SCEN = 1'b0;
        MCEN = 1'b0;
        CCEN = 1'b0;
        case (state)
            SCEN_ST: begin
                DPB  = 1'b1;
                SCEN = 1'b1;
                MCEN = 1'b1;
                CCEN = 1'b1;
            end
            MCEN_ST: begin
                DPB  = 1'b1;
                MCEN = 1'b1;
                CCEN = 1'b1;
            end
            WS, MCEN_CONT, CCR, WFCR: begin
                DPB  = 1'b1;
                CCEN = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with N_dc=4 (T=8); edge numbers count rising edges per scenario.
module tb_button_debouncer;

    logic clk = 1'b0;
    logic reset, pb;
    logic dpb, scen, mcen, ccen;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         idx;
        logic [3:0] exp;   // {dpb, scen, mcen, ccen}
    } vec_t;

    vec_t       vecs [11];
    logic [3:0] hist [0:127];

    button_debouncer #(.N_dc(4)) dut (
        .CLK  (clk),
        .RESET(reset),
        .PB   (pb),
        .DPB  (dpb),
        .SCEN (scen),
        .MCEN (mcen),
        .CCEN (ccen)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive on the falling edge, sample 1 ns after the following rising edge.
    task automatic tick(input logic r, input logic p);
        @(negedge clk);
        reset = r;
        pb    = p;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    function automatic logic [3:0] outs();
        return {dpb, scen, mcen, ccen};
    endfunction

    initial begin
        int first, cnt, cnt2, fall, rises, bad;
        logic prev;

        vecs[0]  = '{2,  4'b0000};
        vecs[1]  = '{10, 4'b0000};
        vecs[2]  = '{11, 4'b1111};
        vecs[3]  = '{12, 4'b1001};
        vecs[4]  = '{43, 4'b1001};
        vecs[5]  = '{44, 4'b1011};
        vecs[6]  = '{45, 4'b1001};
        vecs[7]  = '{52, 4'b1001};
        vecs[8]  = '{53, 4'b1011};
        vecs[9]  = '{62, 4'b1011};
        vecs[10] = '{71, 4'b1011};

        reset = 1'b1;
        pb    = 1'b1;

        // Reset held with the button pressed: everything stays low.
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 1'b1);
            check($sformatf("reset_hold_%0d", k), int'(outs()), 0);
        end
        first = -1;
        for (int k = 1; k <= 30; k++) begin
            tick(1'b0, 1'b1);
            if (scen && first < 0) first = k;
        end
        check("reset_release_scen_edge", first, 11);

        // Long hold: table of per-edge expectations.
        reset_dut();
        for (int k = 1; k <= 100; k++) begin
            tick(1'b0, 1'b1);
            hist[k] = outs();
        end
        for (int i = 0; i < 11; i++)
            check($sformatf("hold_edge%0d", vecs[i].idx), int'(hist[vecs[i].idx]), int'(vecs[i].exp));
        cnt = 0;
        cnt2 = 0;
        for (int k = 1; k <= 100; k++) begin
            cnt  += int'(hist[k][2]);
            cnt2 += int'(hist[k][1]);
        end
        check("hold_scen_count", cnt, 1);
        check("hold_mcen_count", cnt2, 8);
        bad = 0;
        for (int k = 11; k <= 100; k++) if (hist[k][3] != 1'b1 || hist[k][0] != 1'b1) bad++;
        check("hold_dpb_ccen_high", bad, 0);

        // Short bounce: shorter than T, no output activity at all.
        reset_dut();
        bad = 0;
        for (int k = 1; k <= 25; k++) begin
            tick(1'b0, (k <= 5));
            if (outs() != 4'b0000) bad++;
        end
        check("bounce_activity", bad, 0);

        // Release glitch: low 4, high 3, then low for good.
        reset_dut();
        cnt = 0;
        cnt2 = 0;
        bad = 0;
        fall = -1;
        for (int k = 1; k <= 60; k++) begin
            tick(1'b0, (k <= 20) || (k >= 25 && k <= 27));
            cnt  += int'(scen);
            cnt2 += int'(mcen);
            if (k >= 11 && k <= 38 && !dpb) bad++;
            if (k > 11 && !dpb && fall < 0) fall = k;
        end
        check("glitch_scen_count", cnt, 1);
        check("glitch_mcen_count", cnt2, 1);
        check("glitch_dpb_dropouts", bad, 0);
        check("glitch_dpb_fall_edge", fall, 39);

        // Reset while in the auto-repeat gap with the button still held.
        reset_dut();
        for (int k = 1; k <= 46; k++) tick(1'b0, 1'b1);
        check("midhold_state_outs", int'(outs()), 4'b1001);
        tick(1'b1, 1'b1);
        check("midhold_reset_outs", int'(outs()), 0);
        first = -1;
        bad = 0;
        for (int k = 48; k <= 70; k++) begin
            tick(1'b0, 1'b1);
            if (scen && first < 0) first = k;
            if (k < 58 && outs() != 4'b0000) bad++;
        end
        check("midhold_quiet_after_reset", bad, 0);
        check("midhold_scen_edge", first, 58);

        // Two clean presses separated by 20 low clocks.
        reset_dut();
        cnt = 0;
        rises = 0;
        prev = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            tick(1'b0, (k <= 15) || (k >= 36 && k <= 50));
            cnt += int'(scen);
            if (dpb && !prev) rises++;
            prev = dpb;
        end
        check("two_press_scen_count", cnt, 2);
        check("two_press_dpb_intervals", rises, 2);
        check("two_press_final_dpb", int'(dpb), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
